// File: rtl/radar_grid_gen.sv
// radar_grid_gen: 3-stage radar-scope overlay (range rings, six bearing spokes, ping-pong sweep)
module radar_grid_gen #(
  parameter int BIT_WIDTH       = 10,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int CY_OFFSET       = 26,
  parameter int N_RINGS         = 4,
  parameter int RING_STEP       = 80,
  parameter int LINE_WIDTH      = 1,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic                 iVGA_CLK,
  input  logic                 iRST_n,
  input  logic [BIT_WIDTH-1:0] iVGA_X,
  input  logic [BIT_WIDTH-1:0] iVGA_Y,
  input  logic                 iValid,
  input  logic                 iFrameStart,
  input  logic                 iFull,
  input  logic [5:0]           iSpokeMask,
  input  logic                 iSweepEn,
  output logic                 oValid,
  output logic                 oGrid,
  output logic                 oSweep,
  output logic [2:0]           oSweepIdx
);
  localparam int CW   = BIT_WIDTH + 1;
  localparam int SW   = BIT_WIDTH + 6;
  localparam int SQW  = 2 * CW;
  localparam int D2W  = 2 * CW + 1;
  localparam int LW   = LINE_WIDTH;
  localparam int RMAX = N_RINGS * RING_STEP + LW;
  localparam int CNTW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic signed [CW-1:0] CX = CW'(H_ACTIVE / 2);
  localparam logic signed [CW-1:0] CY = CW'(V_ACTIVE - CY_OFFSET);
  localparam logic [D2W-1:0] RMAX2 = D2W'(RMAX * RMAX);

  typedef enum logic {UP, DOWN} state_t;

  state_t state, state_n;
  logic [2:0] idx_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic last;

  logic signed [CW-1:0] dx1, dy1;
  logic v1, full1, sen1;
  logic [5:0] mask1;
  logic [2:0] sidx1;

  logic signed [SW-1:0] dxe, dye, adx;
  logic signed [SQW-1:0] dxw, dyw;
  logic neg, up;
  logic [5:0] sp;

  logic [SQW-1:0] dxsq, dysq;
  logic v2, full2, neg2, sen2;
  logic [5:0] mask2, sp2;
  logic [2:0] sidx2;

  logic [D2W-1:0] d2;
  logic ring, in_r;

  // |k*a - d| <= t, evaluated wide enough that no intermediate can wrap
  function automatic logic near(input logic signed [SW-1:0] a, input logic signed [SW-1:0] d,
                                input int k, input int t);
    logic signed [SW-1:0] e;
    e = a * SW'(k) - d;
    return (e < 0 ? -e : e) <= SW'(t);
  endfunction

  // Sweep state, index and frame counter
  always_ff @(posedge iVGA_CLK or negedge iRST_n)
    if (!iRST_n) begin
      state     <= UP;
      oSweepIdx <= 3'd0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      oSweepIdx <= idx_n;
      cnt       <= cnt_n;
    end

  // Sweep stepping: ping-pong between spokes 0 and 5 every FRAMES_PER_STEP frames
  always_comb begin
    state_n = state;
    idx_n   = oSweepIdx;
    cnt_n   = cnt;
    last    = cnt == CNTW'(FRAMES_PER_STEP - 1);
    if (iFrameStart && iSweepEn) begin
      cnt_n = last ? '0 : cnt + 1'b1;
      if (last && state == UP) begin
        idx_n   = oSweepIdx == 3'd5 ? 3'd4 : oSweepIdx + 3'd1;
        state_n = oSweepIdx == 3'd5 ? DOWN : UP;
      end else if (last) begin
        idx_n   = oSweepIdx == 3'd0 ? 3'd1 : oSweepIdx - 3'd1;
        state_n = oSweepIdx == 3'd0 ? UP : DOWN;
      end
    end
  end

  // Stage 1: origin-relative offsets plus per-pixel controls
  always_ff @(posedge iVGA_CLK or negedge iRST_n)
    if (!iRST_n) begin
      dx1   <= '0;
      dy1   <= '0;
      v1    <= 1'b0;
      full1 <= 1'b0;
      mask1 <= '0;
      sidx1 <= '0;
      sen1  <= 1'b0;
    end else begin
      dx1   <= $signed({1'b0, iVGA_X}) - CX;
      dy1   <= CY - $signed({1'b0, iVGA_Y});
      v1    <= iValid;
      full1 <= iFull;
      mask1 <= iSpokeMask;
      sidx1 <= oSweepIdx;
      sen1  <= iSweepEn;
    end

  assign dxe = SW'(dx1);
  assign dye = SW'(dy1);
  assign dxw = SQW'(dx1);
  assign dyw = SQW'(dy1);
  assign neg = dx1[CW-1];
  assign up  = !dy1[CW-1];
  assign adx = neg ? -dxe : dxe;
  assign sp  = {up & ~neg & near(adx, dye, 1, LW),
                up & ~neg & near(adx, dye, 2, LW),
                up & ~neg & near(adx, dye, 6, 3 * LW),
                up &  neg & near(adx, dye, 6, 3 * LW),
                up &  neg & near(adx, dye, 2, LW),
                up &  neg & near(adx, dye, 1, LW)};

  // Stage 2: squares and angular spoke hits (range limit applied later)
  always_ff @(posedge iVGA_CLK or negedge iRST_n)
    if (!iRST_n) begin
      dxsq  <= '0;
      dysq  <= '0;
      v2    <= 1'b0;
      full2 <= 1'b0;
      neg2  <= 1'b0;
      mask2 <= '0;
      sp2   <= '0;
      sidx2 <= '0;
      sen2  <= 1'b0;
    end else begin
      dxsq  <= dxw * dxw;
      dysq  <= dyw * dyw;
      v2    <= v1;
      full2 <= full1;
      neg2  <= !up;
      mask2 <= mask1;
      sp2   <= sp;
      sidx2 <= sidx1;
      sen2  <= sen1;
    end

  assign d2   = D2W'(dxsq) + D2W'(dysq);
  assign in_r = d2 <= RMAX2;

  // Ring membership against constant squared radius bands
  always_comb begin
    ring = 1'b0;
    for (int i = 0; i < N_RINGS; i++)
      ring = ring | (d2 >= D2W'((RING_STEP * (i + 1) - LW) * (RING_STEP * (i + 1) - LW)) &&
                     d2 <= D2W'((RING_STEP * (i + 1) + LW) * (RING_STEP * (i + 1) + LW)));
  end

  // Stage 3: registered outputs, gated by the delayed valid
  always_ff @(posedge iVGA_CLK or negedge iRST_n)
    if (!iRST_n) begin
      oValid <= 1'b0;
      oGrid  <= 1'b0;
      oSweep <= 1'b0;
    end else begin
      oValid <= v2;
      oGrid  <= v2 & ((ring & (full2 | ~neg2)) | (|(sp2 & mask2) & in_r));
      oSweep <= v2 & sen2 & sp2[sidx2] & in_r;
    end
endmodule

// File: tb/tb_radar_grid_gen.sv
// tb_radar_grid_gen: randomized and directed checks against a geometric reference model
module tb_radar_grid_gen;
  localparam int CX = 320, CY = 454, LW = 1, STEP = 80, NR = 4, FPS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] x, y;
  logic valid, fs, full, sen;
  logic [5:0] mask;
  logic ov, og, osw;
  logic [2:0] oidx;

  typedef struct { logic v; logic g; logic s; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int frames = 0, steps = 0;
  int ks[6] = '{1, 2, 6, 6, 2, 1};
  int ts[6] = '{1, 1, 3, 3, 1, 1};

  always #5 clk = ~clk;

  radar_grid_gen dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVGA_X(x), .iVGA_Y(y), .iValid(valid),
    .iFrameStart(fs), .iFull(full), .iSpokeMask(mask), .iSweepEn(sen),
    .oValid(ov), .oGrid(og), .oSweep(osw), .oSweepIdx(oidx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Sweep position as a triangle wave over completed steps: 0..5..0 with period 10
  function automatic int cur_idx();
    int p;
    p = steps % 10;
    return p <= 5 ? p : 10 - p;
  endfunction

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  // {grid, sweep} for one pixel from the geometric definitions
  function automatic logic [1:0] ref_px(input int px, input int py, input logic pfull,
                                        input logic [5:0] pmask, input logic psen, input int idx);
    int dx, dy, d2, r;
    logic rg;
    logic [5:0] hit;
    dx = px - CX;
    dy = CY - py;
    d2 = dx * dx + dy * dy;
    rg = 1'b0;
    for (int i = 0; i < NR; i++) begin
      r = STEP * (i + 1);
      if ((r - LW) * (r - LW) <= d2 && d2 <= (r + LW) * (r + LW)) rg = 1'b1;
    end
    if (dy < 0 && !pfull) rg = 1'b0;
    for (int s = 0; s < 6; s++)
      hit[s] = dy >= 0 && d2 <= (NR * STEP + LW) * (NR * STEP + LW) &&
               (s < 3 ? dx < 0 : dx >= 0) && iabs(ks[s] * iabs(dx) - dy) <= ts[s];
    return {rg | (|(hit & pmask)), psen & hit[idx]};
  endfunction

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back('{1'b0, 1'b0, 1'b0});
    frames = 0;
    steps = 0;
  endtask

  task automatic cycle(input int px, input int py, input logic pv, input logic pfs,
                       input logic pfull, input logic [5:0] pmask, input logic psen,
                       input string tag);
    exp_t e;
    logic [1:0] r;
    @(negedge clk);
    e = q.pop_front();
    check({tag, "_valid"}, ov, e.v);
    check({tag, "_grid"}, og, e.g);
    check({tag, "_sweep"}, osw, e.s);
    check({tag, "_idx"}, oidx, cur_idx());
    x = px[9:0];
    y = py[9:0];
    valid = pv;
    fs = pfs;
    full = pfull;
    mask = pmask;
    sen = psen;
    r = ref_px(px & 1023, py & 1023, pfull, pmask, psen, cur_idx());
    q.push_back('{pv, pv & r[1], pv & r[0]});
    if (pfs && psen) begin
      frames++;
      if (frames == FPS) begin
        frames = 0;
        steps++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    fs = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int s, adx, dx, dy, px, py;
    rst_n = 1'b0;
    x = '0; y = '0; valid = 1'b0; fs = 1'b0; full = 1'b0; mask = 6'h3F; sen = 1'b0;
    #1;
    check("rst_valid", ov, 0);
    check("rst_grid", og, 0);
    check("rst_sweep", osw, 0);
    check("rst_idx", oidx, 0);
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    cycle(400, 454, 1, 0, 0, 6'h3F, 0, "ring0_x");
    cycle(320, 374, 1, 0, 0, 6'h3F, 0, "ring0_y");
    cycle(396, 478, 1, 0, 0, 6'h3F, 0, "below_half");
    cycle(396, 478, 1, 0, 1, 6'h3F, 0, "below_full");
    cycle(420, 354, 1, 0, 0, 6'h3F, 0, "spoke5_on");
    cycle(420, 354, 1, 0, 0, 6'h1F, 0, "spoke5_masked");
    cycle(420, 354, 0, 0, 0, 6'h3F, 0, "spoke5_invalid");
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 6'h3F, 0, "flush");

    for (int n = 1; n <= 48; n++) begin
      cycle(220, 354, 1, 1, 0, 6'h3F, 1, "sweep_pulse");
      cycle(220, 354, 1, 0, 0, 6'h3F, 1, "sweep_px");
      cycle(220, 354, 1, 0, 0, 6'h3F, 1, "sweep_px");
    end

    do_reset();
    for (int n = 0; n < 8; n++) begin
      cycle(300, 334, 1, 1, 0, 6'h3F, 1, "hold_pre");
      cycle(300, 334, 1, 0, 0, 6'h3F, 1, "hold_pre");
    end
    for (int n = 0; n < 10; n++) begin
      cycle(300, 334, 1, 1, 0, 6'h3F, 0, "hold_off");
      cycle(300, 334, 1, 0, 0, 6'h3F, 0, "hold_off");
    end
    for (int i = 0; i < 3; i++) cycle(300, 334, 1, 0, 0, 6'h3F, 0, "hold_off");
    check("hold_idx2", oidx, 2);

    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 2))
        0: begin
          s = $urandom_range(0, 5);
          adx = $urandom_range(0, 150);
          dx = s < 3 ? -adx : adx;
          dy = ks[s] * adx + $urandom_range(0, 8) - 4;
          px = CX + dx;
          py = CY - dy;
        end
        1: begin
          s = STEP * $urandom_range(1, NR) + $urandom_range(0, 4) - 2;
          if ($urandom_range(0, 1) == 1) begin
            px = CX + ($urandom_range(0, 1) == 1 ? s : -s);
            py = CY + $urandom_range(0, 6) - 3;
          end else begin
            px = CX + $urandom_range(0, 6) - 3;
            py = CY + ($urandom_range(0, 3) == 0 ? s : -s);
          end
        end
        default: begin
          px = $urandom_range(0, 1023);
          py = $urandom_range(0, 1023);
        end
      endcase
      cycle(px, py, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, 6'($urandom_range(0, 63)),
            $urandom_range(0, 7) != 0, "rand");
    end

    do_reset();
    for (int n = 0; n < 4; n++) cycle(420, 354, 1, 1, 0, 6'h3F, 1, "pre_rst");
    for (int n = 0; n < 6; n++) cycle(420, 354, 1, 0, 0, 6'h3F, 1, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", ov, 0);
    check("async_grid", og, 0);
    check("async_sweep", osw, 0);
    check("async_idx", oidx, 0);
    valid = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) cycle(400, 454, 1, 0, 0, 6'h3F, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
